// File: rtl/uart_rx_cfg.sv
// UART receiver with a programmable baud tick, runtime parity/stop selection,
// break detection and a first-word-fall-through FIFO of {ferr, perr, data}.
module uart_rx_cfg #(
    parameter int DBIT   = 8,
    parameter int OVS    = 16,
    parameter int DVSR_W = 16,
    parameter int FIFO_W = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [DVSR_W-1:0] i_dvsr,
    input  logic [1:0]        i_parity_mode,
    input  logic              i_two_stop,
    input  logic              i_rx,
    input  logic              i_rd_uart,
    input  logic              i_clr_overrun,
    output logic [DBIT-1:0]   o_r_data,
    output logic              o_parity_err,
    output logic              o_frame_err,
    output logic              o_rx_empty,
    output logic              o_rx_full,
    output logic              o_overrun,
    output logic              o_busy
);
    localparam int SW    = $clog2(OVS);
    localparam int NW    = $clog2(DBIT);
    localparam int DEPTH = 2**FIFO_W;

    typedef struct packed {
        logic            ferr;
        logic            perr;
        logic [DBIT-1:0] data;
    } rx_word_t;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    // Divisor is re-latched only at wrap so a mid-period change cannot skip a tick.
    logic [DVSR_W-1:0] tcnt, dvsr_q;
    logic              tick;
    assign tick = (tcnt == dvsr_q);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            tcnt   <= '0;
            dvsr_q <= '0;
        end else if (tick) begin
            tcnt   <= '0;
            dvsr_q <= i_dvsr;
        end else begin
            tcnt   <= tcnt + DVSR_W'(1);
        end
    end

    logic [1:0] sync;
    logic       rx_s;
    assign rx_s = sync[1];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) sync <= 2'b11;
        else         sync <= {sync[0], i_rx};
    end

    state_t          state_q, state_n;
    logic [SW-1:0]   s_q, s_n;
    logic [NW-1:0]   n_q, n_n;
    logic [DBIT-1:0] b_q, b_n;
    logic            perr_q, perr_n, ferr_q, ferr_n, stop2_q, stop2_n;
    logic [1:0]      mode_q, mode_n;
    logic            two_q, two_n, push_q, push_n;
    rx_word_t        word_q, word_n;
    logic            par_en, fe;

    assign par_en = mode_q[0] ^ mode_q[1];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            stop2_q <= 1'b0;
            mode_q  <= 2'b00;
            two_q   <= 1'b0;
            push_q  <= 1'b0;
            word_q  <= '0;
        end else begin
            state_q <= state_n;
            s_q     <= s_n;
            n_q     <= n_n;
            b_q     <= b_n;
            perr_q  <= perr_n;
            ferr_q  <= ferr_n;
            stop2_q <= stop2_n;
            mode_q  <= mode_n;
            two_q   <= two_n;
            push_q  <= push_n;
            word_q  <= word_n;
        end
    end

    always_comb begin
        state_n = state_q;
        s_n     = s_q;
        n_n     = n_q;
        b_n     = b_q;
        perr_n  = perr_q;
        ferr_n  = ferr_q;
        stop2_n = stop2_q;
        mode_n  = mode_q;
        two_n   = two_q;
        push_n  = 1'b0;
        word_n  = word_q;
        fe      = ferr_q | ~rx_s;
        case (state_q)
            IDLE: begin
                mode_n = i_parity_mode;
                two_n  = i_two_stop;
                if (!rx_s) begin
                    state_n = START;
                    s_n     = '0;
                    perr_n  = 1'b0;
                    ferr_n  = 1'b0;
                    stop2_n = 1'b0;
                end
            end
            START: if (tick) begin
                if (s_q == SW'(OVS/2-1)) begin
                    state_n = rx_s ? IDLE : DATA;
                    s_n     = '0;
                    n_n     = '0;
                end else s_n = s_q + SW'(1);
            end
            DATA: if (tick) begin
                if (s_q == SW'(OVS-1)) begin
                    s_n = '0;
                    b_n = {rx_s, b_q[DBIT-1:1]};
                    if (n_q == NW'(DBIT-1)) state_n = par_en ? PARITY : STOP;
                    else                    n_n = n_q + NW'(1);
                end else s_n = s_q + SW'(1);
            end
            PARITY: if (tick) begin
                if (s_q == SW'(OVS-1)) begin
                    s_n     = '0;
                    perr_n  = mode_q[1] ? ~^{b_q, rx_s} : ^{b_q, rx_s};
                    state_n = STOP;
                end else s_n = s_q + SW'(1);
            end
            STOP: if (tick) begin
                if (s_q == SW'(OVS-1)) begin
                    s_n    = '0;
                    ferr_n = fe;
                    if (two_q && !stop2_q) begin
                        stop2_n = 1'b1;
                    end else begin
                        // Leave mid-stop-bit so a back-to-back start edge is not missed.
                        push_n  = 1'b1;
                        word_n  = '{ferr: fe, perr: perr_q, data: b_q};
                        state_n = fe ? BREAK : IDLE;
                    end
                end else s_n = s_q + SW'(1);
            end
            BREAK: if (rx_s) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign o_busy = (state_q != IDLE);

    logic [FIFO_W:0] wptr, rptr;
    rx_word_t        mem [DEPTH];
    rx_word_t        head;
    logic            empty, full, rd_en, wr_en, ovr_set;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[FIFO_W] != rptr[FIFO_W]) &&
                     (wptr[FIFO_W-1:0] == rptr[FIFO_W-1:0]);
    assign rd_en   = i_rd_uart & ~empty;
    assign wr_en   = push_q & (~full | rd_en);
    assign ovr_set = push_q & full & ~rd_en;

    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wptr[FIFO_W-1:0]] <= word_q;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wptr      <= '0;
            rptr      <= '0;
            o_overrun <= 1'b0;
        end else begin
            if (wr_en) wptr <= wptr + (FIFO_W+1)'(1);
            if (rd_en) rptr <= rptr + (FIFO_W+1)'(1);
            if (ovr_set)            o_overrun <= 1'b1;
            else if (i_clr_overrun) o_overrun <= 1'b0;
        end
    end

    // Head is forced to zero while empty so reset values hold without clearing memory.
    assign head         = mem[rptr[FIFO_W-1:0]];
    assign o_r_data     = empty ? '0   : head.data;
    assign o_parity_err = empty ? 1'b0 : head.perr;
    assign o_frame_err  = empty ? 1'b0 : head.ferr;
    assign o_rx_empty   = empty;
    assign o_rx_full    = full;

endmodule
